// File: rtl/rvfi_tracker.sv
// Retirement-record collector: gathers RVFI fields per ROB entry as an instruction
// moves through the core and emits completed records, in commit order, to the monitor.
module rvfi_tracker #(
  parameter int ROB_DEPTH = 16,
  parameter int CHANNELS  = 1,
  localparam int RW       = $clog2(ROB_DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,

  input  logic                   dis_valid,
  input  logic [RW-1:0]          dis_rob_id,
  input  logic [31:0]            dis_inst,
  input  logic [31:0]            dis_pc,
  input  logic [4:0]             dis_rs1_addr,
  input  logic [4:0]             dis_rs2_addr,
  input  logic [4:0]             dis_rd_addr,

  input  logic                   wb_valid,
  input  logic [RW-1:0]          wb_rob_id,
  input  logic [31:0]            wb_rs1_rdata,
  input  logic [31:0]            wb_rs2_rdata,
  input  logic [31:0]            wb_rd_wdata,

  input  logic                   br_valid,
  input  logic [RW-1:0]          br_rob_id,
  input  logic [31:0]            br_pc_wdata,

  input  logic                   mem_valid,
  input  logic [RW-1:0]          mem_rob_id,
  input  logic [31:0]            mem_addr,
  input  logic [31:0]            mem_rdata,
  input  logic [31:0]            mem_wdata,
  input  logic [3:0]             mem_rmask,
  input  logic [3:0]             mem_wmask,

  input  logic                   flush,
  input  logic [CHANNELS-1:0]    cmt_valid,
  input  logic [CHANNELS*RW-1:0] cmt_rob_id,

  output logic                   mon_valid     [CHANNELS],
  output logic [63:0]            mon_order     [CHANNELS],
  output logic [31:0]            mon_inst      [CHANNELS],
  output logic                   mon_halt      [CHANNELS],
  output logic [4:0]             mon_rs1_addr  [CHANNELS],
  output logic [4:0]             mon_rs2_addr  [CHANNELS],
  output logic [31:0]            mon_rs1_rdata [CHANNELS],
  output logic [31:0]            mon_rs2_rdata [CHANNELS],
  output logic [4:0]             mon_rd_addr   [CHANNELS],
  output logic [31:0]            mon_rd_wdata  [CHANNELS],
  output logic [4:0]             mon_frd_addr  [CHANNELS],
  output logic [31:0]            mon_frd_wdata [CHANNELS],
  output logic [31:0]            mon_pc_rdata  [CHANNELS],
  output logic [31:0]            mon_pc_wdata  [CHANNELS],
  output logic [31:0]            mon_mem_addr  [CHANNELS],
  output logic [3:0]             mon_mem_rmask [CHANNELS],
  output logic [3:0]             mon_mem_wmask [CHANNELS],
  output logic [31:0]            mon_mem_rdata [CHANNELS],
  output logic [31:0]            mon_mem_wdata [CHANNELS],

  output logic                   err
);

  localparam logic [31:0] HALT_INST = 32'hF000_2013;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc_rdata;
    logic [31:0] pc_wdata;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic [31:0] rs1_rdata;
    logic [31:0] rs2_rdata;
    logic [31:0] rd_wdata;
    logic [31:0] mem_addr;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;
    logic [31:0] mem_wdata;
  } rec_t;

  rec_t                 tbl [ROB_DEPTH];
  logic [ROB_DEPTH-1:0] live;
  logic [ROB_DEPTH-1:0] live_nxt;
  logic [63:0]          order_q;

  rec_t                 dis_rec;
  rec_t                 cmt_rec [CHANNELS];
  logic [RW-1:0]        cmt_id  [CHANNELS];
  logic [63:0]          cmt_ofs [CHANNELS];
  logic [63:0]          cmt_cnt;
  logic                 violation;

  logic wb_ok;
  logic br_ok;
  logic mem_ok;

  assign wb_ok  = wb_valid  & live[wb_rob_id];
  assign br_ok  = br_valid  & live[br_rob_id];
  assign mem_ok = mem_valid & live[mem_rob_id];

  // NOTE: every variable written in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    dis_rec           = '0;
    dis_rec.inst      = dis_inst;
    dis_rec.pc_rdata  = dis_pc;
    dis_rec.pc_wdata  = dis_pc + 32'd4;
    dis_rec.rs1_addr  = dis_rs1_addr;
    dis_rec.rs2_addr  = dis_rs2_addr;
    dis_rec.rd_addr   = dis_rd_addr;
  end

  // NOTE: the record table is deliberately not reset; live bits qualify every entry, so its contents never matter after reset.
  // NOTE: sequential state uses non-blocking assignments; the dispatch write comes last so it wins over a same-id update.
  always_ff @(posedge clk) begin
    if (wb_ok) begin
      tbl[wb_rob_id].rs1_rdata <= wb_rs1_rdata;
      tbl[wb_rob_id].rs2_rdata <= wb_rs2_rdata;
      tbl[wb_rob_id].rd_wdata  <= wb_rd_wdata;
    end
    if (br_ok) begin
      tbl[br_rob_id].pc_wdata <= br_pc_wdata;
    end
    if (mem_ok) begin
      tbl[mem_rob_id].mem_addr  <= mem_addr;
      tbl[mem_rob_id].mem_rmask <= mem_rmask;
      tbl[mem_rob_id].mem_wmask <= mem_wmask;
      tbl[mem_rob_id].mem_rdata <= mem_rdata;
      tbl[mem_rob_id].mem_wdata <= mem_wdata;
    end
    if (dis_valid) begin
      tbl[dis_rob_id] <= dis_rec;
    end
  end

  // Commit read path: table entry with same-cycle updates forwarded, plus per-channel order offset.
  always_comb begin
    cmt_cnt = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      cmt_id[i]  = cmt_rob_id[i*RW +: RW];
      cmt_ofs[i] = cmt_cnt;
      cmt_cnt    = cmt_cnt + 64'(cmt_valid[i]);
      cmt_rec[i] = tbl[cmt_id[i]];
      if (wb_ok && wb_rob_id == cmt_id[i]) begin
        cmt_rec[i].rs1_rdata = wb_rs1_rdata;
        cmt_rec[i].rs2_rdata = wb_rs2_rdata;
        cmt_rec[i].rd_wdata  = wb_rd_wdata;
      end
      if (br_ok && br_rob_id == cmt_id[i]) begin
        cmt_rec[i].pc_wdata = br_pc_wdata;
      end
      if (mem_ok && mem_rob_id == cmt_id[i]) begin
        cmt_rec[i].mem_addr  = mem_addr;
        cmt_rec[i].mem_rmask = mem_rmask;
        cmt_rec[i].mem_wmask = mem_wmask;
        cmt_rec[i].mem_rdata = mem_rdata;
        cmt_rec[i].mem_wdata = mem_wdata;
      end
    end
  end

  // Commit retires first, flush then squashes whatever is left, dispatch allocates last.
  always_comb begin
    live_nxt  = live;
    violation = (cmt_valid & (cmt_valid + CHANNELS'(1))) != '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (cmt_valid[i]) begin
        if (!live[cmt_id[i]]) violation = 1'b1;
        live_nxt[cmt_id[i]] = 1'b0;
      end
    end
    if (flush) live_nxt = '0;
    if (dis_valid) live_nxt[dis_rob_id] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      live    <= '0;
      order_q <= '0;
      err     <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        mon_valid[i]     <= 1'b0;
        mon_order[i]     <= '0;
        mon_inst[i]      <= '0;
        mon_halt[i]      <= 1'b0;
        mon_rs1_addr[i]  <= '0;
        mon_rs2_addr[i]  <= '0;
        mon_rs1_rdata[i] <= '0;
        mon_rs2_rdata[i] <= '0;
        mon_rd_addr[i]   <= '0;
        mon_rd_wdata[i]  <= '0;
        mon_frd_addr[i]  <= '0;
        mon_frd_wdata[i] <= '0;
        mon_pc_rdata[i]  <= '0;
        mon_pc_wdata[i]  <= '0;
        mon_mem_addr[i]  <= '0;
        mon_mem_rmask[i] <= '0;
        mon_mem_wmask[i] <= '0;
        mon_mem_rdata[i] <= '0;
        mon_mem_wdata[i] <= '0;
      end
    end else begin
      live    <= live_nxt;
      order_q <= order_q + cmt_cnt;
      err     <= err | violation;
      for (int i = 0; i < CHANNELS; i++) begin
        mon_valid[i] <= cmt_valid[i];
        if (cmt_valid[i]) begin
          mon_order[i]     <= order_q + cmt_ofs[i];
          mon_inst[i]      <= cmt_rec[i].inst;
          mon_halt[i]      <= cmt_rec[i].inst == HALT_INST;
          mon_rs1_addr[i]  <= cmt_rec[i].rs1_addr;
          mon_rs2_addr[i]  <= cmt_rec[i].rs2_addr;
          mon_rs1_rdata[i] <= cmt_rec[i].rs1_rdata;
          mon_rs2_rdata[i] <= cmt_rec[i].rs2_rdata;
          mon_rd_addr[i]   <= cmt_rec[i].rd_addr;
          mon_rd_wdata[i]  <= (cmt_rec[i].rd_addr == 5'd0) ? 32'd0 : cmt_rec[i].rd_wdata;
          mon_frd_addr[i]  <= '0;
          mon_frd_wdata[i] <= '0;
          mon_pc_rdata[i]  <= cmt_rec[i].pc_rdata;
          mon_pc_wdata[i]  <= cmt_rec[i].pc_wdata;
          mon_mem_addr[i]  <= cmt_rec[i].mem_addr;
          mon_mem_rmask[i] <= cmt_rec[i].mem_rmask;
          mon_mem_wmask[i] <= cmt_rec[i].mem_wmask;
          mon_mem_rdata[i] <= cmt_rec[i].mem_rdata;
          mon_mem_wdata[i] <= cmt_rec[i].mem_wdata;
        end
      end
    end
  end

endmodule
